// File: rtl/fpu_div_pkg.sv
// Shared types and constants for the FP32 divider sequencing controller.
`timescale 1ns/1ps
package fpu_div_pkg;

    localparam int FP32_W             = 32;
    localparam int DEFAULT_DIV_CYCLES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } div_state_e;

endpackage

// File: rtl/fpu_div_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant plus the pointer value to load on a grant.
`timescale 1ns/1ps
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    input  logic       en,
    output logic [1:0] grant,
    output logic       ptr_next
);

    always_comb begin
        grant    = 2'b00;
        ptr_next = ptr;
        if (en) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
        // The loser of this round gets priority next time.
        if (|grant) begin
            ptr_next = ~grant[1];
        end
    end

endmodule

// File: rtl/fpu_div_arbiter.sv
// Shares one multicycle FP32 divider between two requesters and returns the
// quotient with the requester's tag over a valid/ready response port.
`timescale 1ns/1ps
module fpu_div_arbiter
    import fpu_div_pkg::*;
#(
    parameter int DIV_CYCLES = DEFAULT_DIV_CYCLES,
    parameter int TAG_W      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [FP32_W-1:0] req0_a,
    input  logic [FP32_W-1:0] req0_b,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [FP32_W-1:0] req1_a,
    input  logic [FP32_W-1:0] req1_b,
    input  logic [TAG_W-1:0]  req1_tag,
    output logic [FP32_W-1:0] div_n1,
    output logic [FP32_W-1:0] div_n2,
    input  logic [FP32_W-1:0] div_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [FP32_W-1:0] rsp_result,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_id,
    output logic              busy
);

    localparam int                CNT_W    = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ptr_q, ptr_d;
    logic [FP32_W-1:0] n1_q, n1_d, n2_q, n2_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              id_q, id_d;
    logic [FP32_W-1:0] res_q, res_d;
    logic [TAG_W-1:0]  rtag_q, rtag_d;
    logic              rid_q, rid_d;

    logic [1:0] grant;
    logic       ptr_next;
    logic       accept;
    logic       exec_done;

    rr_arb2 u_arb (
        .valid    ({req1_valid, req0_valid}),
        .ptr      (ptr_q),
        .en       (state_q == ST_IDLE),
        .grant    (grant),
        .ptr_next (ptr_next)
    );

    assign accept     = |grant;
    assign exec_done  = (state_q == ST_EXEC) && (cnt_q == '0);
    assign req0_ready = grant[0] & req0_valid;
    assign req1_ready = grant[1] & req1_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)                 state_d = ST_EXEC;
            ST_EXEC: if (exec_done)              state_d = ST_RESP;
            ST_RESP: if (rsp_valid && rsp_ready) state_d = ST_IDLE;
            default:                             state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rsp_valid = (state_q == ST_RESP);
        busy      = (state_q == ST_EXEC) || (state_q == ST_RESP);
    end

    // Operands stay on the divider until the next accept, so they are stable
    // for the whole EXEC window and through any response back-pressure.
    always_comb begin
        cnt_d  = cnt_q;
        ptr_d  = ptr_q;
        n1_d   = n1_q;
        n2_d   = n2_q;
        tag_d  = tag_q;
        id_d   = id_q;
        res_d  = res_q;
        rtag_d = rtag_q;
        rid_d  = rid_q;
        if (accept) begin
            n1_d  = grant[1] ? req1_a   : req0_a;
            n2_d  = grant[1] ? req1_b   : req0_b;
            tag_d = grant[1] ? req1_tag : req0_tag;
            id_d  = grant[1];
            cnt_d = CNT_LOAD;
            ptr_d = ptr_next;
        end else if (exec_done) begin
            res_d  = div_result;
            rtag_d = tag_q;
            rid_d  = id_q;
        end else if (state_q == ST_EXEC) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            ptr_q  <= 1'b0;
            n1_q   <= '0;
            n2_q   <= '0;
            tag_q  <= '0;
            id_q   <= 1'b0;
            res_q  <= '0;
            rtag_q <= '0;
            rid_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ptr_q  <= ptr_d;
            n1_q   <= n1_d;
            n2_q   <= n2_d;
            tag_q  <= tag_d;
            id_q   <= id_d;
            res_q  <= res_d;
            rtag_q <= rtag_d;
            rid_q  <= rid_d;
        end
    end

    assign div_n1     = n1_q;
    assign div_n2     = n2_q;
    assign rsp_result = res_q;
    assign rsp_tag    = rtag_q;
    assign rsp_id     = rid_q;

endmodule

// File: tb/tb_fpu_div_arbiter.sv
// Directed bench: three controller instances (DIV_CYCLES 1, 4, 8) share stimulus,
// each driving a divider stub that yields a poison value until its inputs have settled.
`timescale 1ns/1ps
module tb_fpu_div_arbiter;
    import fpu_div_pkg::*;

    localparam int          TAG_W  = 5;
    localparam int          NDUT   = 3;
    localparam int          M      = 1;
    localparam logic [31:0] POISON = 32'h7FBADBAD;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid, req1_valid, rsp_ready;
    logic [31:0]      req0_a, req0_b, req1_a, req1_b;
    logic [TAG_W-1:0] req0_tag, req1_tag;

    logic             req0_ready [NDUT];
    logic             req1_ready [NDUT];
    logic             rsp_valid  [NDUT];
    logic             rsp_id     [NDUT];
    logic             busy       [NDUT];
    logic [31:0]      div_n1     [NDUT];
    logic [31:0]      div_n2     [NDUT];
    logic [31:0]      div_result [NDUT];
    logic [31:0]      rsp_result [NDUT];
    logic [TAG_W-1:0] rsp_tag    [NDUT];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(negedge clk) cyc = cyc + 1;

    function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h40800000_40000000: return 32'h40000000;
            64'h3F800000_3F800000: return 32'h3F800000;
            64'hBF000000_3E800000: return 32'hC0000000;
            64'h40400000_3F800000: return 32'h40400000;
            64'h41200000_40000000: return 32'h40A00000;
            default:               return a ^ b;
        endcase
    endfunction

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int DC = (gi == 0) ? 1 : (gi == 1) ? 4 : 8;
        int chg_stamp = 0;
        always @(div_n1[gi] or div_n2[gi]) chg_stamp = cyc;
        assign div_result[gi] = ((cyc - chg_stamp) >= DC) ? quot(div_n1[gi], div_n2[gi]) : POISON;

        fpu_div_arbiter #(.DIV_CYCLES(DC), .TAG_W(TAG_W)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req0_valid (req0_valid),
            .req0_ready (req0_ready[gi]),
            .req0_a     (req0_a),
            .req0_b     (req0_b),
            .req0_tag   (req0_tag),
            .req1_valid (req1_valid),
            .req1_ready (req1_ready[gi]),
            .req1_a     (req1_a),
            .req1_b     (req1_b),
            .req1_tag   (req1_tag),
            .div_n1     (div_n1[gi]),
            .div_n2     (div_n2[gi]),
            .div_result (div_result[gi]),
            .rsp_valid  (rsp_valid[gi]),
            .rsp_ready  (rsp_ready),
            .rsp_result (rsp_result[gi]),
            .rsp_tag    (rsp_tag[gi]),
            .rsp_id     (rsp_id[gi]),
            .busy       (busy[gi])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_rsp(input int idx, input int budget, output int lat);
        lat = -1;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk); #1;
            if (rsp_valid[idx]) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic set_req0(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
        req0_valid = 1'b1; req0_a = a; req0_b = b; req0_tag = t;
    endtask

    task automatic set_req1(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
        req1_valid = 1'b1; req1_a = a; req1_b = b; req1_tag = t;
    endtask

    task automatic chk_rsp(input string tag, input int lat, input int exp_lat,
                           input logic [31:0] res, input logic [TAG_W-1:0] t, input logic id);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, rsp_result[M], res);
        chk({tag, "_tag"}, 32'(rsp_tag[M]), 32'(t));
        chk({tag, "_id"},  32'(rsp_id[M]), 32'(id));
        $display("rsp %s lat=%0d res=%h tag=%0d id=%0d", tag, lat, rsp_result[M], rsp_tag[M], rsp_id[M]);
    endtask

    initial begin
        int lat;
        int lats [NDUT];
        bit seen;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_tag = '0;
        req1_a = '0; req1_b = '0; req1_tag = '0;

        // Reset state, sampled while rst is still asserted.
        repeat (2) @(posedge clk); #1;
        chk("rst_busy",   32'(busy[M]), 32'd0);
        chk("rst_rvalid", 32'(rsp_valid[M]), 32'd0);
        chk("rst_result", rsp_result[M], 32'd0);
        chk("rst_tag",    32'(rsp_tag[M]), 32'd0);
        chk("rst_id",     32'(rsp_id[M]), 32'd0);
        chk("rst_n1",     div_n1[M], 32'd0);
        chk("rst_n2",     div_n2[M], 32'd0);
        chk("rst_rdy0",   32'(req0_ready[M]), 32'd0);
        chk("rst_rdy1",   32'(req1_ready[M]), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single request: 4.0 / 2.0.
        set_req0(32'h40800000, 32'h40000000, 5'd3);
        #1;
        chk("single_rdy0", 32'(req0_ready[M]), 32'd1);
        chk("single_rdy1", 32'(req1_ready[M]), 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        chk("single_busy", 32'(busy[M]), 32'd1);
        chk("single_n1", div_n1[M], 32'h40800000);
        chk("single_n2", div_n2[M], 32'h40000000);
        wait_rsp(M, 20, lat);
        chk_rsp("single", lat, 4, 32'h40000000, 5'd3, 1'b0);
        take_rsp();
        chk("single_done_valid", 32'(rsp_valid[M]), 32'd0);
        chk("single_done_busy",  32'(busy[M]), 32'd0);

        // Contention after reset: req0 first, then back-pressure while req1 waits.
        do_reset();
        set_req0(32'h3F800000, 32'h3F800000, 5'd1);
        set_req1(32'hBF000000, 32'h3E800000, 5'd2);
        #1;
        chk("cont_rdy0", 32'(req0_ready[M]), 32'd1);
        chk("cont_rdy1", 32'(req1_ready[M]), 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        wait_rsp(M, 20, lat);
        chk_rsp("cont0", lat, 4, 32'h3F800000, 5'd1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(rsp_valid[M]), 32'd1);
            chk("bp_result", rsp_result[M], 32'h3F800000);
            chk("bp_tag", 32'(rsp_tag[M]), 32'd1);
            chk("bp_rdy1", 32'(req1_ready[M]), 32'd0);
            chk("bp_n1", div_n1[M], 32'h3F800000);
        end
        take_rsp();
        chk("release_rdy1", 32'(req1_ready[M]), 32'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        chk("release_n1", div_n1[M], 32'hBF000000);
        wait_rsp(M, 20, lat);
        chk_rsp("cont1", lat, 4, 32'hC0000000, 5'd2, 1'b1);
        take_rsp();

        // Lone req0 moves priority to req1; the next simultaneous pair starts with req1.
        set_req0(32'h40400000, 32'h3F800000, 5'd6);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        wait_rsp(M, 20, lat);
        chk_rsp("lone0", lat, 4, 32'h40400000, 5'd6, 1'b0);
        take_rsp();
        set_req0(32'h3F800000, 32'h3F800000, 5'd10);
        set_req1(32'hBF000000, 32'h3E800000, 5'd11);
        #1;
        chk("pair_rdy0", 32'(req0_ready[M]), 32'd0);
        chk("pair_rdy1", 32'(req1_ready[M]), 32'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_rsp(M, 20, lat);
        chk_rsp("pair1", lat, 4, 32'hC0000000, 5'd11, 1'b1);
        take_rsp();
        chk("pair_rdy0_next", 32'(req0_ready[M]), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        wait_rsp(M, 20, lat);
        chk_rsp("pair0", lat, 4, 32'h3F800000, 5'd10, 1'b0);
        take_rsp();

        // Reset in the second EXEC cycle discards the request.
        set_req0(32'h40800000, 32'h40000000, 5'd7);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("mrst_busy",   32'(busy[M]), 32'd0);
        chk("mrst_valid",  32'(rsp_valid[M]), 32'd0);
        chk("mrst_n1",     div_n1[M], 32'd0);
        chk("mrst_n2",     div_n2[M], 32'd0);
        chk("mrst_result", rsp_result[M], 32'd0);
        chk("mrst_tag",    32'(rsp_tag[M]), 32'd0);
        chk("mrst_id",     32'(rsp_id[M]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (rsp_valid[M]) seen = 1'b1;
        end
        chk("mrst_no_rsp", 32'(seen), 32'd0);
        set_req0(32'h40400000, 32'h3F800000, 5'd9);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        wait_rsp(M, 20, lat);
        chk_rsp("post_rst", lat, 4, 32'h40400000, 5'd9, 1'b0);
        take_rsp();

        // req1 shows up for one cycle while busy and withdraws.
        set_req0(32'h41200000, 32'h40000000, 5'd4);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        set_req1(32'h3F800000, 32'h3F800000, 5'd12);
        #1;
        chk("wd_rdy1", 32'(req1_ready[M]), 32'd0);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_rsp(M, 20, lat);
        chk_rsp("wd", lat, 3, 32'h40A00000, 5'd4, 1'b0);
        take_rsp();
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (rsp_valid[M]) seen = 1'b1;
        end
        chk("wd_no_rsp", 32'(seen), 32'd0);
        chk("wd_busy", 32'(busy[M]), 32'd0);

        // DIV_CYCLES sweep: all three instances accept the same request together.
        do_reset();
        set_req0(32'h40800000, 32'h40000000, 5'd5);
        #1;
        for (int i = 0; i < NDUT; i++) chk("sweep_rdy0", 32'(req0_ready[i]), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        for (int i = 0; i < NDUT; i++) lats[i] = -1;
        for (int n = 1; n <= 12; n++) begin
            for (int i = 0; i < NDUT; i++) begin
                if (lats[i] < 0 && rsp_valid[i]) lats[i] = n;
            end
            @(posedge clk); #1;
        end
        chk("sweep_lat_dc1", 32'(lats[0] - 1), 32'd1);
        chk("sweep_lat_dc4", 32'(lats[1] - 1), 32'd4);
        chk("sweep_lat_dc8", 32'(lats[2] - 1), 32'd8);
        for (int i = 0; i < NDUT; i++) begin
            chk("sweep_result", rsp_result[i], 32'h40000000);
            chk("sweep_tag", 32'(rsp_tag[i]), 32'd5);
            $display("sweep dut=%0d lat=%0d res=%h", i, lats[i] - 1, rsp_result[i]);
        end
        take_rsp();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fpu_div_arbiter.md
# fpu_div_arbiter

Sequencing and sharing controller for the single-precision FP divider (`DivFPU_Flowchart`, ports `N1`, `N2`, `result`). Two requesters share the divider, for example the FDIV issue slot and a microcoded sequence. The block accepts one request at a time with a 2-way round-robin grant and holds the operands stable on the divider for a configurable multicycle window. It then captures the quotient and returns it, with the requester's tag, over a valid/ready response port. The block does not interpret FP data: zero, Inf and NaN operands pass through to the divider unchanged.

## Interface
- `DIV_CYCLES`, 4, cycles the operands are held before `result` is sampled (multicycle-path allowance); legal range ≥1.
- `TAG_W`, 5, width of the opaque request tag (for example the destination register index).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  32  dividend and divisor (IEEE-754 binary32).
- `req0_tag` / `req1_tag`  in  TAG_W  opaque tag, returned with the result.
- `div_n1`, `div_n2`  out  32  registered operands, driving the divider's `N1`/`N2`.
- `div_result`  in  32  divider's combinational `result`.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_result`  out  32  captured quotient.
- `rsp_tag`  out  TAG_W  tag of the served request.
- `rsp_id`  out  1  index of the served requester.
- `busy`  out  1  high in EXEC or RESP.

## Operation
- FSM states and transitions:
  - IDLE: when any request is valid, grant one and go to EXEC.
  - EXEC: hold operands; go to RESP when the count expires.
  - RESP: present the response; go to IDLE on `rsp_valid & rsp_ready`.
- Grant, evaluated only in IDLE:
  - If exactly one `reqN_valid` is high, that requester wins.
  - If both are high, the requester selected by the priority pointer `ptr` wins.
  - `reqN_ready = (state==IDLE) & grant==N & reqN_valid` (combinational). At most one ready is high per cycle.
- Accept (valid & ready) latches:
  - a → `div_n1`, b → `div_n2`;
  - tag → internal tag register; N → internal id register;
  - `cnt ← DIV_CYCLES-1`; `ptr ← ~N`, so the other requester has priority next.
- EXEC: `cnt` decrements each cycle. On the edge where `cnt==0`, capture `rsp_result ← div_result`, `rsp_tag`, `rsp_id`, and go to RESP.
- RESP: `rsp_valid=1`. While `rsp_ready` is low, all `rsp_*` and `div_*` outputs hold and no request is accepted.
- Reset values: state IDLE, `ptr=0`, `cnt=0`, `div_n1=div_n2=0`, `rsp_valid=0`, `rsp_result=0`, `rsp_tag=0`, `rsp_id=0`, `busy=0`, both readies 0.

## Timing
- Accept at edge E0. `rsp_valid` rises after edge E(DIV_CYCLES).
- `div_n1`/`div_n2` are stable from after E0 until the next accept; the divider sees constant inputs for ≥DIV_CYCLES cycles.
- Response handshake at edge Er puts the state in IDLE. The earliest next accept is edge Er+1, so the minimum issue interval is DIV_CYCLES+2 cycles.
- `reqN_valid` dropping before its ready is high means no transaction and no state change.
- Simultaneous new requests while in EXEC or RESP: both readies stay low, and requesters must hold valid, operands and tag stable.
- `rst` asserted mid-operation: an in-flight request is discarded with no response, and all registers return to their reset values immediately (asynchronous).
- DIV_CYCLES=1: `rsp_valid` rises one edge after accept.

## Structure
- Package `fpu_div_pkg` holds:
  - the state enum (IDLE/EXEC/RESP);
  - the FP32 width constant (32);
  - the default DIV_CYCLES.
- Sub-module `rr_arb2`: inputs are 2-bit valid, `ptr` and `en`; outputs are a one-hot grant and the next-pointer value. It is reusable for other shared FPU units.
- The divider is instantiated outside this block, at the FPU top level.

## Test plan
- Single request, DIV_CYCLES=4: req0 with a=0x40800000, b=0x40000000, tag=3 → `rsp_valid` after 4 edges; rsp_result=0x40000000, tag=3, id=0.
- Contention: both valid after reset, req0 with 0x3F800000/0x3F800000 and req1 with 0xBF000000/0x3E800000 → req0 is served first (0x3F800000), then req1 (0xC0000000, id=1). A third back-to-back pair is served starting with req1.
- Back-pressure: hold `rsp_ready=0` for 10 cycles → `rsp_*` stable, both readies low, req1 kept waiting. Release `rsp_ready` → req1 is accepted one cycle later.
- Mid-flight reset: assert `rst` at EXEC cycle 2 → `rsp_valid` stays 0, all outputs return to reset values, and the next request completes normally.
- Operand hold: run a behavioural divider stub whose output is X unless its inputs have been stable for DIV_CYCLES cycles → no X is ever captured on `rsp_result`. Sweep DIV_CYCLES over 1, 4 and 8.
- Withdrawn request: req1_valid is high for one cycle while busy, then drops → no response carries id=1.
